// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the SD sector arbiter.
package sd_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int SD_SECTOR_AW = 26;
  localparam logic SD_OP_READ  = 1'b0;
  localparam logic SD_OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_XFER,
    ST_DONE
  } sd_state_e;

  // Byte counter sticks at all-ones so an overrun can never wrap back to 512.
  function automatic logic [9:0] sat_inc(input logic [9:0] cnt, input logic inc);
    if (inc && (cnt != 10'h3FF)) return cnt + 10'd1;
    return cnt;
  endfunction

endpackage

// File: rtl/sd_sector_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares one SD sector engine between NUM_REQ clients, one sector op at a time,
// round-robin, with byte routing, completion/error pulses and a launch timeout.
//
// state      | meaning
// IDLE       | no owner; grant when controller idle and someone requests
// LAUNCH     | sd_execute high for this one cycle; counters cleared
// WAIT_BUSY  | waiting for controller to raise sd_busy
// XFER       | routing byte strobes to owner until finished_sector
// DONE       | done/err pulse to owner; pointer moves to owner
module sd_sector_arbiter
  import sd_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int SECTOR_AW   = SD_SECTOR_AW,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_op,
  input  logic [NUM_REQ*SECTOR_AW-1:0]   req_sector,
  input  logic [NUM_REQ*8-1:0]           req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             byte_strb,
  output logic [7:0]                     rd_byte,
  output logic [NUM_REQ-1:0]             done,
  output logic [NUM_REQ-1:0]             err,
  output logic                           sd_execute,
  output logic                           sd_op_code,
  output logic [SECTOR_AW-1:0]           sd_sector_address,
  output logic [7:0]                     sd_outgoing_byte,
  input  logic                           sd_busy,
  input  logic                           sd_finished_byte,
  input  logic                           sd_finished_sector,
  input  logic [7:0]                     sd_incoming_byte
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);

  sd_state_e          state;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      owner;
  logic [PW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] pick;
  logic [9:0]         byte_cnt;
  logic [9:0]         cnt_next;
  logic [TW-1:0]      tmr;
  logic [7:0]         rd_hold;
  logic               active;
  logic               byte_hit;
  logic               tmo;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req   (req),
    .ptr   (rr_ptr),
    .en    ((state == ST_IDLE) && !sd_busy),
    .grant (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) pick_idx = PW'(i);
  end

  always_comb begin
    sd_outgoing_byte = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) sd_outgoing_byte = sd_outgoing_byte | req_wdata[i*8 +: 8];
  end

  // A sector-complete while still waiting for busy is handled exactly like XFER.
  assign active    = (state == ST_WAIT_BUSY) || (state == ST_XFER);
  assign byte_hit  = active && sd_finished_byte;
  assign byte_strb = gnt & {NUM_REQ{byte_hit}};
  assign rd_byte   = byte_hit ? sd_incoming_byte : rd_hold;
  assign cnt_next  = sat_inc(byte_cnt, byte_hit);
  assign tmo       = (tmr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      rr_ptr            <= PW'(NUM_REQ - 1);
      owner             <= '0;
      gnt               <= '0;
      done              <= '0;
      err               <= '0;
      sd_execute        <= 1'b0;
      sd_op_code        <= 1'b0;
      sd_sector_address <= '0;
      byte_cnt          <= '0;
      tmr               <= '0;
      rd_hold           <= '0;
    end else begin
      sd_execute <= 1'b0;
      done       <= '0;
      err        <= '0;
      case (state)
        ST_IDLE: begin
          if (|pick) begin
            gnt               <= pick;
            owner             <= pick_idx;
            sd_op_code        <= req_op[pick_idx];
            sd_sector_address <= req_sector[int'(pick_idx)*SECTOR_AW +: SECTOR_AW];
            sd_execute        <= 1'b1;
            state             <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          byte_cnt <= '0;
          // Terminal count lands on the cycle before the err pulse, TIMEOUT_CYC after launch.
          tmr      <= TW'(TIMEOUT_CYC - 2);
          state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY, ST_XFER: begin
          byte_cnt <= cnt_next;
          if (byte_hit) rd_hold <= sd_incoming_byte;
          if (tmo) begin
            err    <= gnt;
            gnt    <= '0;
            rr_ptr <= owner;
            state  <= ST_IDLE;
          end else if (sd_finished_sector) begin
            if (cnt_next == 10'(SECTOR_BYTES)) done <= gnt;
            else                               err  <= gnt;
            state <= ST_DONE;
          end else begin
            tmr <= tmr - TW'(1);
            if ((state == ST_WAIT_BUSY) && sd_busy) state <= ST_XFER;
          end
        end
        ST_DONE: begin
          gnt    <= '0;
          rr_ptr <= owner;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
